// File: rtl/craft_pkg.sv
// Shared definitions for the CRAFT job controller: operand widths, FSM encoding,
// timeout defaults and the job operand payload.
package craft_pkg;

   localparam int unsigned PT_W            = 64;
   localparam int unsigned TW_W            = 64;
   localparam int unsigned KEY_W           = 128;
   localparam int unsigned CNT_W           = 12;
   localparam int unsigned TIMEOUT_DEFAULT = 4095;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   typedef struct packed {
      logic [PT_W-1:0]  plaintext;
      logic [TW_W-1:0]  tweak;
      logic [KEY_W-1:0] key;
   } craft_job_t;

endpackage

// File: rtl/craft_job_slot.sv
// One-entry valid/ready holding register for a pending CRAFT job (operands + tag).
module craft_job_slot
   import craft_pkg::*;
#(
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  craft_job_t       in_job_i,
   input  logic [TAG_W-1:0] in_tag_i,
   input  logic             pop_i,
   output logic             pend_valid_o,
   output logic             pend_valid_nxt_c,
   output craft_job_t       pend_job_o,
   output logic [TAG_W-1:0] pend_tag_o
);

   logic             valid_q, valid_d;
   logic             ready_q;
   logic             push_c;
   craft_job_t       job_q;
   logic [TAG_W-1:0] tag_q;

   // ready is held low through reset and rises on the first edge after release
   always_comb begin
      push_c  = in_valid_i & ready_q;
      valid_d = push_c | (valid_q & ~pop_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         job_q   <= '0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ready_q <= ~valid_d;
         if (push_c) begin
            job_q <= in_job_i;
            tag_q <= in_tag_i;
         end
      end
   end

   assign in_ready_o       = ready_q;
   assign pend_valid_o     = valid_q;
   assign pend_valid_nxt_c = valid_d;
   assign pend_job_o       = job_q;
   assign pend_tag_o       = tag_q;

endmodule

// File: rtl/craft_job_ctrl.sv
// Job controller for an external CRAFT encrypt core: buffers one job, launches the
// core, captures the result or a timeout error, and holds it for downstream.
module craft_job_ctrl
   import craft_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int unsigned TAG_W          = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PT_W-1:0]   in_plaintext,
   input  logic [TW_W-1:0]   in_tweak,
   input  logic [KEY_W-1:0]  in_key,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              core_rst_n,
   output logic [PT_W-1:0]   core_plaintext,
   output logic [TW_W-1:0]   core_tweak,
   output logic [KEY_W-1:0]  core_key,
   input  logic              core_done,
   input  logic [PT_W-1:0]   core_ciphertext,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PT_W-1:0]   out_ciphertext,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic             pend_valid, pend_valid_nxt_c, pop_c, out_free_c;
   craft_job_t       pend_job;
   logic [TAG_W-1:0] pend_tag;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   craft_job_t       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             core_rst_n_q, core_rst_n_d;
   logic             out_valid_q, out_valid_d;
   logic             out_err_q, out_err_d;
   logic [PT_W-1:0]  out_ct_q, out_ct_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic             busy_q, busy_d;

   craft_job_slot #(.TAG_W(TAG_W)) u_slot (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid_i       (in_valid),
      .in_ready_o       (in_ready),
      .in_job_i         ('{plaintext: in_plaintext, tweak: in_tweak, key: in_key}),
      .in_tag_i         (in_tag),
      .pop_i            (pop_c),
      .pend_valid_o     (pend_valid),
      .pend_valid_nxt_c (pend_valid_nxt_c),
      .pend_job_o       (pend_job),
      .pend_tag_o       (pend_tag)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      tag_d       = tag_q;
      out_valid_d = out_valid_q;
      out_err_d   = out_err_q;
      out_ct_d    = out_ct_q;
      out_tag_d   = out_tag_q;
      pop_c       = 1'b0;
      out_free_c  = ~out_valid_q | out_ready;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pend_valid) begin
               op_d    = pend_job;
               tag_d   = pend_tag;
               pop_c   = 1'b1;
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // a completed core wins over a simultaneous timeout; both wait for a free output
            if (core_done && out_free_c) begin
               out_valid_d = 1'b1;
               out_err_d   = 1'b0;
               out_ct_d    = core_ciphertext;
               out_tag_d   = tag_q;
               state_d     = ST_HOLD;
            end else if ((cnt_q == CNT_LAST) && out_free_c) begin
               out_valid_d = 1'b1;
               out_err_d   = 1'b1;
               out_ct_d    = '0;
               out_tag_d   = tag_q;
               state_d     = ST_HOLD;
            end else if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      core_rst_n_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
      busy_d       = (state_d != ST_IDLE) || pend_valid_nxt_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         op_q         <= '0;
         tag_q        <= '0;
         core_rst_n_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_err_q    <= 1'b0;
         out_ct_q     <= '0;
         out_tag_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         tag_q        <= tag_d;
         core_rst_n_q <= core_rst_n_d;
         out_valid_q  <= out_valid_d;
         out_err_q    <= out_err_d;
         out_ct_q     <= out_ct_d;
         out_tag_q    <= out_tag_d;
         busy_q       <= busy_d;
      end
   end

   assign core_rst_n     = core_rst_n_q;
   assign core_plaintext = op_q.plaintext;
   assign core_tweak     = op_q.tweak;
   assign core_key       = op_q.key;
   assign out_valid      = out_valid_q;
   assign out_err        = out_err_q;
   assign out_ciphertext = out_ct_q;
   assign out_tag        = out_tag_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_craft_job_ctrl.sv
// Directed bench for craft_job_ctrl with a behavioural stand-in for the encrypt core.
module tb_craft_job_ctrl;
   import craft_pkg::*;

   localparam int unsigned TAG_W = 4;
   localparam int unsigned TMO   = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid, in_ready;
   logic [63:0]       in_plaintext, in_tweak;
   logic [127:0]      in_key;
   logic [TAG_W-1:0]  in_tag;
   logic              core_rst_n;
   logic [63:0]       core_plaintext, core_tweak, core_ciphertext;
   logic [127:0]      core_key;
   logic              core_done = 1'b0;
   logic              out_valid, out_ready, out_err, busy;
   logic [63:0]       out_ciphertext;
   logic [TAG_W-1:0]  out_tag;

   int n_tests = 0;
   int n_fail  = 0;

   int unsigned core_lat  = 5;
   bit          core_hang = 1'b0;
   logic [7:0]  core_cnt  = 8'd0;

   craft_job_ctrl #(.TIMEOUT_CYCLES(TMO), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_plaintext(in_plaintext), .in_tweak(in_tweak), .in_key(in_key), .in_tag(in_tag),
      .core_rst_n(core_rst_n), .core_plaintext(core_plaintext), .core_tweak(core_tweak),
      .core_key(core_key), .core_done(core_done), .core_ciphertext(core_ciphertext),
      .out_valid(out_valid), .out_ready(out_ready), .out_ciphertext(out_ciphertext),
      .out_tag(out_tag), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model_ct(input logic [63:0] p, input logic [63:0] t,
                                            input logic [127:0] k);
      return p ^ t ^ k[63:0] ^ {k[119:64], k[127:120]};
   endfunction

   // core stand-in: done rises core_lat edges after reset release and holds until reset
   always @(posedge clk) begin
      if (!core_rst_n) begin
         core_cnt  <= 8'd0;
         core_done <= 1'b0;
      end else if (!core_hang && !core_done) begin
         if (32'(core_cnt) + 32'd1 == core_lat) core_done <= 1'b1;
         else core_cnt <= core_cnt + 8'd1;
      end
   end
   assign core_ciphertext = core_done ? model_ct(core_plaintext, core_tweak, core_key) : 64'h0;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic submit(input logic [63:0] p, input logic [63:0] t, input logic [127:0] k,
                         input logic [TAG_W-1:0] tg);
      bit hs;
      hs = 1'b0;
      in_valid = 1'b1; in_plaintext = p; in_tweak = t; in_key = k; in_tag = tg;
      for (int i = 0; i < 100 && !hs; i++) begin
         hs = in_ready;
         tick();
      end
      in_valid = 1'b0;
      chk("submit_handshake", 128'(hs), 128'(1'b1));
   endtask

   task automatic wait_out(input int max, output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < max) begin
         tick();
         n++;
      end
   endtask

   localparam logic [63:0]  P0 = 64'h5734F006D8D88A3E;
   localparam logic [63:0]  T0 = 64'h54CD94FFD0670A58;
   localparam logic [127:0] K0 = 128'h27A6781A43F364BC916708D5FBB5AEFE;

   initial begin
      int n, hs_cnt, got, rises;
      bit hs, stable, quiet;
      logic prev_crn;
      logic [63:0] pa, pb, ta, tb, ct_a;
      logic [127:0] ka, kb;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_plaintext = '0; in_tweak = '0; in_key = '0; in_tag = '0;
      repeat (2) @(posedge clk);
      #1;
      // reset values
      chk("rst_in_ready",   128'(in_ready),       128'(1'b0));
      chk("rst_out_valid",  128'(out_valid),      128'(1'b0));
      chk("rst_out_err",    128'(out_err),        128'(1'b0));
      chk("rst_out_ct",     128'(out_ciphertext), 128'(64'h0));
      chk("rst_out_tag",    128'(out_tag),        128'(4'h0));
      chk("rst_core_rst_n", 128'(core_rst_n),     128'(1'b0));
      chk("rst_core_key",   128'(core_key),       128'(0));
      chk("rst_busy",       128'(busy),           128'(1'b0));
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 128'(in_ready), 128'(1'b1));

      // single job, latency and operand registers
      submit(P0, T0, K0, 4'h3);
      chk("j1_ready_low", 128'(in_ready), 128'(1'b0));
      chk("j1_busy",      128'(busy),     128'(1'b1));
      tick();
      chk("j1_launch_rst", 128'(core_rst_n),     128'(1'b0));
      chk("j1_core_pt",    128'(core_plaintext), 128'(P0));
      chk("j1_core_key",   128'(core_key),       K0);
      tick();
      chk("j1_run_rst",    128'(core_rst_n), 128'(1'b1));
      wait_out(20, n);
      chk("j1_latency",  128'(n), 128'(6));
      chk("j1_valid",    128'(out_valid), 128'(1'b1));
      chk("j1_tag",      128'(out_tag), 128'(4'h3));
      chk("j1_err",      128'(out_err), 128'(1'b0));
      chk("j1_ct",       128'(out_ciphertext), 128'(model_ct(P0, T0, K0)));
      chk("j1_tw_hold",  128'(core_tweak), 128'(T0));
      tick();
      chk("j1_pulse",    128'(out_valid), 128'(1'b0));
      chk("j1_core_rst", 128'(core_rst_n), 128'(1'b0));
      chk("j1_idle",     128'(busy), 128'(1'b0));

      // three jobs back-to-back with in_valid held
      hs_cnt = 0; got = 0; rises = 0; prev_crn = core_rst_n;
      in_valid = 1'b1; in_tag = 4'd1;
      in_plaintext = 64'hA5A5_0000_0000_0001; in_tweak = 64'h0F0F_1111_2222_0001;
      in_key = {64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0001};
      for (int cyc = 0; cyc < 300 && got < 3; cyc++) begin
         hs = in_valid && in_ready;
         tick();
         if (core_rst_n && !prev_crn) rises++;
         prev_crn = core_rst_n;
         if (hs) begin
            hs_cnt++;
            if (hs_cnt == 2) chk("b2b_ready_drop", 128'(in_ready), 128'(1'b0));
            if (hs_cnt < 3) begin
               in_tag       = 4'(hs_cnt + 1);
               in_plaintext = 64'hA5A5_0000_0000_0000 ^ 64'(hs_cnt + 1);
               in_tweak     = 64'h0F0F_1111_2222_0000 ^ 64'(hs_cnt + 1);
               in_key       = {64'h1234_5678_9ABC_DEF0, 64'(hs_cnt + 1)};
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            chk("b2b_tag", 128'(out_tag), 128'(got + 1));
            chk("b2b_ct", 128'(out_ciphertext),
                128'(model_ct(64'hA5A5_0000_0000_0000 ^ 64'(got + 1),
                              64'h0F0F_1111_2222_0000 ^ 64'(got + 1),
                              {64'h1234_5678_9ABC_DEF0, 64'(got + 1)})));
            got++;
         end
      end
      in_valid = 1'b0;
      chk("b2b_results",    128'(got),    128'(3));
      chk("b2b_handshakes", 128'(hs_cnt), 128'(3));
      chk("b2b_launches",   128'(rises),  128'(3));
      repeat (2) tick();

      // output back-pressure with a second job stalled in RUN
      pa = 64'h0123_4567_89AB_CDEF; ta = 64'hFEDC_BA98_7654_3210; ka = {2{64'hCAFE_F00D_DEAD_BEEF}};
      pb = 64'h1111_2222_3333_4444; tb = 64'h5555_6666_7777_8888; kb = {64'h9999_AAAA_BBBB_CCCC, 64'h0};
      ct_a = model_ct(pa, ta, ka);
      out_ready = 1'b0;
      submit(pa, ta, ka, 4'h5);
      submit(pb, tb, kb, 4'h6);
      wait_out(40, n);
      chk("bp_a_valid", 128'(out_valid), 128'(1'b1));
      chk("bp_a_tag",   128'(out_tag),   128'(4'h5));
      stable = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (out_valid !== 1'b1 || out_tag !== 4'h5 || out_ciphertext !== ct_a || out_err !== 1'b0)
            stable = 1'b0;
         tick();
      end
      chk("bp_stable",     128'(stable),         128'(1'b1));
      chk("bp_b_running",  128'(core_rst_n),     128'(1'b1));
      chk("bp_b_operands", 128'(core_plaintext), 128'(pb));
      out_ready = 1'b1;
      tick();
      chk("bp_b_valid", 128'(out_valid),      128'(1'b1));
      chk("bp_b_tag",   128'(out_tag),        128'(4'h6));
      chk("bp_b_ct",    128'(out_ciphertext), 128'(model_ct(pb, tb, kb)));
      tick();
      chk("bp_b_taken", 128'(out_valid), 128'(1'b0));
      tick();

      // timeout with a core that never finishes
      core_hang = 1'b1;
      submit(64'hDEAD_0000_0000_BEEF, 64'h1, 128'h2, 4'h9);
      n = 0;
      while (core_rst_n !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("to_run_entry", 128'(core_rst_n), 128'(1'b1));
      wait_out(40, n);
      chk("to_cycles", 128'(n),              128'(16));
      chk("to_err",    128'(out_err),        128'(1'b1));
      chk("to_ct",     128'(out_ciphertext), 128'(64'h0));
      chk("to_tag",    128'(out_tag),        128'(4'h9));
      tick();
      chk("to_taken",  128'(out_valid),  128'(1'b0));
      chk("to_idle",   128'(core_rst_n), 128'(1'b0));
      chk("to_busy",   128'(busy),       128'(1'b0));
      core_hang = 1'b0;

      // reset in RUN cycle 10 with a job pending
      core_lat = 14;
      submit(64'hAAAA, 64'hBBBB, 128'hCCCC, 4'hA);
      submit(64'h1234, 64'h5678, 128'h9ABC, 4'hB);
      repeat (9) tick();
      chk("mr_in_run", 128'(core_rst_n), 128'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("mr_out_valid", 128'(out_valid),      128'(1'b0));
      chk("mr_out_ct",    128'(out_ciphertext), 128'(64'h0));
      chk("mr_out_tag",   128'(out_tag),        128'(4'h0));
      chk("mr_core_rst",  128'(core_rst_n),     128'(1'b0));
      chk("mr_core_pt",   128'(core_plaintext), 128'(64'h0));
      chk("mr_in_ready",  128'(in_ready),       128'(1'b0));
      chk("mr_busy",      128'(busy),           128'(1'b0));
      repeat (3) tick();
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid !== 1'b0) quiet = 1'b0;
      end
      chk("mr_no_result", 128'(quiet), 128'(1'b1));
      chk("mr_discarded", 128'(busy),  128'(1'b0));
      core_lat = 5;
      submit(P0 ^ 64'hFF, T0, K0, 4'hC);
      wait_out(30, n);
      chk("mr_new_latency", 128'(n),              128'(8));
      chk("mr_new_tag",     128'(out_tag),        128'(4'hC));
      chk("mr_new_ct",      128'(out_ciphertext), 128'(model_ct(P0 ^ 64'hFF, T0, K0)));
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
